// File: rtl/mem_responder_if.sv
// Request/response bus between the processor (master) and the data memory responder (slave).
interface mem_responder_if;
    localparam int unsigned DATA_W = 16;

    logic              req;
    logic              r_wbar;
    logic [DATA_W-1:0] ao;
    logic [DATA_W-1:0] edb_in;
    logic [DATA_W-1:0] edb_out;
    logic              ack;
    logic              busy;
    logic              error;

    modport master (
        output req, r_wbar, ao, edb_in,
        input  edb_out, ack, busy, error
    );

    modport slave (
        input  req, r_wbar, ao, edb_in,
        output edb_out, ack, busy, error
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed data memory behind a handshaken bus: accepts one request,
// waits WAIT_STATES cycles, performs the access and pulses ack for one cycle.
module mem_responder #(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ABUS_W = 16;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [ABUS_W-1:0] addr_q;
    logic [ABUS_W-1:0] addr_n;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_n;
    logic              rw_q;
    logic              rw_n;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_n;
    logic              ack_q;
    logic              ack_n;
    logic              busy_q;
    logic              busy_n;
    logic              err_q;
    logic              err_n;
    logic              mem_we_c;
    logic              in_range_c;
    logic [ADDR_W-1:0] idx_c;

    logic [DATA_W-1:0] mem [DEPTH];

    // Full-width range test: addresses at or above DEPTH never alias into the array.
    assign in_range_c = ({16'd0, addr_q} < 32'(DEPTH));
    assign idx_c      = addr_q[ADDR_W-1:0];

    assign bus.edb_out = dout_q;
    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;
    assign bus.error   = err_q;

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            rw_q   <= 1'b0;
            dout_q <= '0;
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            data_q <= data_n;
            rw_q   <= rw_n;
            dout_q <= dout_n;
            ack_q  <= ack_n;
            busy_q <= busy_n;
            err_q  <= err_n;
        end
    end

    // Array write port; reset on the access edge suppresses the write. Contents are not reset.
    always_ff @(posedge clock) begin
        if (!reset && mem_we_c) begin
            mem[idx_c] <= data_q;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = addr_q;
        data_n   = data_q;
        rw_n     = rw_q;
        dout_n   = dout_q;
        ack_n    = ack_q;
        busy_n   = busy_q;
        err_n    = err_q;
        mem_we_c = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    addr_n  = bus.ao;
                    data_n  = bus.edb_in;
                    rw_n    = bus.r_wbar;
                    cnt_n   = CNT_W'(WAIT_STATES);
                    busy_n  = 1'b1;
                    state_n = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    ack_n   = 1'b1;
                    state_n = ST_RESP;
                    if (!in_range_c) begin
                        dout_n = '0;
                        err_n  = 1'b1;
                    end else if (rw_q) begin
                        dout_n = mem[idx_c];
                        err_n  = 1'b0;
                    end else begin
                        mem_we_c = 1'b1;
                        dout_n   = '0;
                        err_n    = 1'b0;
                    end
                end
            end

            ST_RESP: begin
                ack_n   = 1'b0;
                busy_n  = 1'b0;
                err_n   = 1'b0;
                dout_n  = '0;
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end
endmodule
